// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, a one-entry skid buffer and redirect drain.
// Optional `IF_PERF_CNT_EN adds fetched/bubble performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] pend_q, pend_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  logic        mem_ack;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  // An ack is only meaningful against a request we are actually presenting.
  assign mem_ack  = imem_ack & req_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign target   = redirect_pc & ~32'd3;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    pend_d       = pend_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;

    unique case (state_q)
      StFetch: begin
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          pc4_d   = 32'd0;
          // With a request still in flight its data must be drained before refetching.
          if (mem_ack || !req_q) begin
            pc_d = target;
          end else begin
            pend_d  = target;
            state_d = StDrain;
          end
        end else if (stall) begin
          if (mem_ack) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
            pc_d         = pc_plus4;
            state_d      = StHold;
          end
        end else if (mem_ack) begin
          valid_d = 1'b1;
          instr_d = imem_rdata;
          pc4_d   = pc_plus4;
          pc_d    = pc_plus4;
        end else begin
          valid_d = 1'b0;
        end
      end
      StHold: begin
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          pc4_d   = 32'd0;
          pc_d    = target;
          state_d = StFetch;
        end else if (!stall) begin
          valid_d = 1'b1;
          instr_d = skid_instr_q;
          pc4_d   = skid_pc4_q;
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          pc4_d   = 32'd0;
          pend_d  = target;
        end
        if (mem_ack) begin
          pc_d    = redirect ? target : pend_q;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      pend_q       <= 32'd0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc4_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= (state_d != StHold);
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      pend_q       <= pend_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;

`ifdef IF_PERF_CNT_EN
  logic        fetched_now;
  logic [31:0] fetched_q;
  logic [31:0] bubbles_q;

  assign fetched_now = !redirect && !stall &&
                       ((state_q == StFetch && mem_ack) || (state_q == StHold));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q <= 32'd0;
      bubbles_q <= 32'd0;
    end else begin
      if (fetched_now) fetched_q <= fetched_q + 32'd1;
      if (!valid_q && !stall) bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, PC-wrap sequence and randomized run against a
// fetch-order model with a random-latency instruction memory.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_instr, if_id_pc_plus4;

  logic        wrap_rst;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc4;

`ifdef IF_PERF_CNT_EN
  logic [31:0] p_fetched, p_bubbles, wp_fetched, wp_bubbles;
`endif

  always #5 clk = ~clk;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched  (p_fetched),
    .perf_bubbles  (p_bubbles)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk           (clk),
    .reset         (wrap_rst),
    .stall         (1'b0),
    .redirect      (1'b0),
    .redirect_pc   (32'd0),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_ack      (1'b1),
    .imem_rdata    (32'h1234_5678),
    .if_id_valid   (w_valid),
    .if_id_instr   (w_instr),
    .if_id_pc_plus4(w_pc4)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched  (wp_fetched),
    .perf_bubbles  (wp_bubbles)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } vec_t;

  vec_t vecs[19];

  // Reference model: program-order fetch with a skid queue and a discard flag for drained data.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  logic        m_started, m_discard, m_valid;
  logic [31:0] m_fetch, m_pend, m_instr, m_pc4;
  ent_t        m_buf[$];
  int unsigned m_fetched, m_bubbles;
  int          wait_cnt;

  task automatic model_reset();
    m_started = 1'b0;
    m_discard = 1'b0;
    m_fetch   = 32'd0;
    m_pend    = 32'd0;
    m_buf.delete();
    m_valid   = 1'b0;
    m_instr   = 32'd0;
    m_pc4     = 32'd0;
    m_fetched = 0;
    m_bubbles = 0;
    wait_cnt  = $urandom_range(0, 2);
  endtask

  task automatic model_step(input logic exp_req);
    logic [31:0] tgt;
    ent_t        e;
    if (!m_valid && !stall) m_bubbles++;
    if (redirect) begin
      tgt     = redirect_pc & ~32'd3;
      m_valid = 1'b0;
      m_instr = 32'd0;
      m_pc4   = 32'd0;
      m_buf.delete();
      if (exp_req && !imem_ack) begin
        m_discard = 1'b1;
        m_pend    = tgt;
      end else begin
        m_discard = 1'b0;
        m_fetch   = tgt;
      end
    end else if (m_discard) begin
      if (imem_ack) begin
        m_fetch   = m_pend;
        m_discard = 1'b0;
      end
    end else if (stall) begin
      if (imem_ack) begin
        m_buf.push_back('{imem_rdata, m_fetch + 32'd4});
        m_fetch = m_fetch + 32'd4;
      end
    end else if (m_buf.size() > 0) begin
      e = m_buf.pop_front();
      m_valid = 1'b1;
      m_instr = e.instr;
      m_pc4   = e.pc4;
      m_fetched++;
    end else if (imem_ack) begin
      m_valid = 1'b1;
      m_instr = imem_rdata;
      m_pc4   = m_fetch + 32'd4;
      m_fetch = m_fetch + 32'd4;
      m_fetched++;
    end else begin
      m_valid = 1'b0;
    end
    m_started = 1'b1;
  endtask

  initial begin
    logic exp_req;

    //           stall redir rpc          ack  rdata          req  addr         vld  instr          pc4
    vecs[0]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,      1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h2000_0000, 1'b1, 32'h0,     1'b0, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h2000_0004, 1'b1, 32'h4,     1'b1, 32'h2000_0000, 32'h4};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h2000_0008, 1'b1, 32'h8,     1'b1, 32'h2000_0004, 32'h8};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h2000_000C, 1'b1, 32'hC,     1'b1, 32'h2000_0008, 32'hC};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h10,     1'b1, 32'h2000_0008, 32'hC};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h10,     1'b1, 32'h2000_0008, 32'hC};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h10,     1'b1, 32'h2000_0008, 32'hC};
    vecs[8]  = '{1'b1, 1'b1, 32'h41,      1'b1, 32'h2000_0010, 1'b1, 32'h10,    1'b1, 32'h2000_000C, 32'h10};
    vecs[9]  = '{1'b0, 1'b1, 32'h103,     1'b0, 32'h0,        1'b1, 32'h40,     1'b0, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h2000_0040, 1'b1, 32'h40,    1'b0, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h2000_0100, 1'b1, 32'h100,   1'b0, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h104,    1'b1, 32'h2000_0100, 32'h104};
    vecs[13] = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h104,    1'b0, 32'h2000_0100, 32'h104};
    vecs[14] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h2000_0104, 1'b1, 32'h104,   1'b0, 32'h2000_0100, 32'h104};
    vecs[15] = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h108,    1'b1, 32'h2000_0104, 32'h108};
    vecs[16] = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h108,    1'b0, 32'h2000_0104, 32'h108};
    vecs[17] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h2000_0108, 1'b1, 32'h108,   1'b0, 32'h2000_0104, 32'h108};
    vecs[18] = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h10C,    1'b1, 32'h2000_0108, 32'h10C};

    reset       = 1'b1;
    wrap_rst    = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed table: zero-wait, stall with skid, redirect+stall, drain, 2-wait-state memory.
    for (int i = 0; i < 19; i++) begin
      check($sformatf("v%0d.req", i),   32'(imem_req),    32'(vecs[i].req));
      check($sformatf("v%0d.addr", i),  imem_addr,        vecs[i].addr);
      check($sformatf("v%0d.valid", i), 32'(if_id_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d.instr", i), if_id_instr,      vecs[i].instr);
      check($sformatf("v%0d.pc4", i),   if_id_pc_plus4,   vecs[i].pc4);
      stall       = vecs[i].stall;
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      imem_ack    = vecs[i].ack;
      imem_rdata  = vecs[i].rdata;
      @(negedge clk);
    end

    // PC wrap from 0xFFFF_FFFC with an always-acking memory.
    wrap_rst = 1'b0;
    check("wrap.req0", 32'(w_req), 32'd0);
    @(negedge clk);
    check("wrap.req1", 32'(w_req), 32'd1);
    check("wrap.addr1", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap.addr2", w_addr, 32'h0000_0000);
    check("wrap.valid2", 32'(w_valid), 32'd1);
    check("wrap.instr2", w_instr, 32'h1234_5678);
    check("wrap.pc4_2", w_pc4, 32'h0000_0000);
    @(negedge clk);
    check("wrap.addr3", w_addr, 32'h0000_0004);
    check("wrap.pc4_3", w_pc4, 32'h0000_0004);

    // Randomized run against the model, with an asynchronous reset in the middle.
    stall    = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        imem_ack = 1'b0;
        reset    = 1'b1;
        #1;
        check("rst.req", 32'(imem_req), 32'd0);
        check("rst.valid", 32'(if_id_valid), 32'd0);
        check("rst.addr", imem_addr, 32'd0);
        check("rst.pc4", if_id_pc_plus4, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
      end
      exp_req = m_started && (m_buf.size() == 0);
      check("rnd.req", 32'(imem_req), 32'(exp_req));
      check("rnd.addr", imem_addr, m_fetch);
      check("rnd.valid", 32'(if_id_valid), 32'(m_valid));
      check("rnd.instr", if_id_instr, m_instr);
      check("rnd.pc4", if_id_pc_plus4, m_pc4);
`ifdef IF_PERF_CNT_EN
      check("rnd.perf_fetched", p_fetched, 32'(m_fetched));
      check("rnd.perf_bubbles", p_bubbles, 32'(m_bubbles));
`endif
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      imem_ack    = exp_req && (wait_cnt == 0);
      imem_rdata  = imem_ack ? (32'h2000_0000 + m_fetch) : $urandom;
      if (imem_ack) wait_cnt = $urandom_range(0, 2);
      else if (exp_req && wait_cnt > 0) wait_cnt--;
      model_step(exp_req);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
